tx_enc_8b10b: RTL and testbench
===============================

// Module: tx_enc_8b10b
// PURPOSE
// 4-octet-per-clock IEEE 8b/10b encoder, one per lane.
// Sits directly downstream of the JESD204 TX lane (tx) and consumes its DO octets.
// Its K flags come from the ILA / character-replacement control path.
// Output feeds the SerDes parallel interface.
// PARAMETERS
// none (datapath fixed at 4 octets / 40 code bits per CLK)
// PORTS
// CLK    in   1        lane clock, rising edge
// RST_n  in   1        asynchronous active-low reset
// EN     in   1        clock enable; low = all registers hold
// DI     in   [3:0][7:0]  octets, DI[0] first on the wire; bits HGFEDCBA = DI[i][7:0]
// KI     in   [3:0]    1 = DI[i] is a control character
// DO     out  [3:0][9:0]  code groups, DO[0] first; DO[i][0]=a ... [5]=i, [6]=f ... [9]=j; bit 0 sent first
// RD     out  1        running disparity after DO[3]; 0 = RD-, 1 = RD+
// K_ERR  out  [3:0]    1 = KI[i] set on a non-encodable control code
// BEHAVIOUR
// - Reset (async assert, sync release):
//   - DO = 0, RD = 0 (RD-), K_ERR = 0.
// - Latency: exactly 1 CLK. DI/KI sampled on an EN=1 edge appear on DO/K_ERR/RD after that edge.
// - Disparity chain, combinational within one cycle:
//   - rd0 = registered RD; octet i encodes with rd_i; rd_(i+1) = result of code i.
//   - RD register <= rd4.
// - Per octet, split into 5b/6b (EDCBA -> abcdei) then 3b/4b (HGF -> fghj).
//   - The 4b sub-block uses the RD left after the 6b sub-block.
//   - Neutral sub-block: disparity unchanged.
//   - Unbalanced sub-block: choose the variant that moves disparity toward zero, then flip RD.
//   - Sub-blocks D.7 (111000/000111) and x.3 (1100/0011) follow the standard alternate selection by RD.
// - D.x.7 uses alternate A7 (0111 / 1000) when either holds:
//   - RD- and x in {17,18,20};
//   - RD+ and x in {11,13,14}.
//   - Otherwise P7 (1110 / 0001).
// - Valid K codes: K28.0-K28.7, K23.7, K27.7, K29.7, K30.7.
//   - K28.y uses 6b 001111/110000. K28.1/.5/.6 take 4b per K table (x.1/x.5/x.6 inverted by RD).
//   - K.x.7 always uses A7.
// - KI=1 on any other value:
//   - encode as the data character Dx.y;
//   - K_ERR[i]=1 for that cycle's output; disparity chain continues normally.
// - EN low: DO, RD, K_ERR hold their values; no disparity advance.
// - RST_n asserted mid-stream: immediate return to the reset values; next encode starts from RD-.
// - Encoding is identical for all four slots. Disparity is never reset except by RST_n.
// TESTING
// - Reset, then DI=4x8'hBC, KI=4'hF.
//   - Next cycle DO[0..3] (abcdei fghj) = 001111 1010, 110000 0101, 001111 1010, 110000 0101.
//   - RD=0, K_ERR=0.
// - From RD-: DI=4x8'h00, KI=0.
//   - Each DO = 100111 0100; RD stays 0.
//   - Then DI[0]=8'hBC, KI=4'h1: DO[0] = 001111 1010, RD=1 after slot 0.
// - Set RD+ via a single K28.5, then DI[0]=8'hEB (D11.7), KI=0.
//   - DO[0] = 110100 1000 (A7).
//   - DI=8'hF1 (D17.7) from RD- gives 100011 0111.
// - DI=8'hB5 (D21.5) in all slots, from either RD.
//   - DO = 101010 1010 in all slots; RD unchanged.
// - KI=4'h2, DI[1]=8'h00 (invalid K): DO[1] = D0.0 encoding, K_ERR=4'h2.
//   - KI=4'hF with DI=8'h7C/FC/F7/FB/FD/FE: K_ERR=0.
// - Hold EN=0 for 3 cycles with changing DI: DO/RD frozen.
//   - Pulse RST_n low mid-stream: DO=0, RD=0 asynchronously.
//   - First post-reset K28.5 encodes as 001111 1010.

Source files
------------

// File: rtl/tx_enc_8b10b.sv
// tx_enc_8b10b: four-octet-per-clock IEEE 8b/10b encoder with running disparity chained across slots
module tx_enc_8b10b (
  input  logic            CLK,
  input  logic            RST_n,
  input  logic            EN,
  input  logic [3:0][7:0] DI,
  input  logic [3:0]      KI,
  output logic [3:0][9:0] DO,
  output logic            RD,
  output logic [3:0]      K_ERR
);
  // RD- variants written abcdei / fghj with a (resp. f) as the MSB
  localparam logic [5:0] t6 [32] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
  localparam logic [3:0] t4d [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
  localparam logic [3:0] t4k [8] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};
  function automatic logic [11:0] enc(input logic [7:0] d, input logic k, input logic rd);
    logic [4:0] x;
    logic [2:0] y;
    logic k28, kv, u6, r6, a7, u4;
    logic [5:0] c6, o6, s6;
    logic [3:0] c4, o4, s4;
    x = d[4:0];
    y = d[7:5];
    k28 = k && x == 5'd28;
    kv = k28 || (k && y == 3'd7 && x inside {5'd23, 5'd27, 5'd29, 5'd30});
    c6 = k28 ? 6'b001111 : t6[x];
    u6 = $countones(c6) != 3;
    o6 = (rd && (u6 || x == 5'd7)) ? ~c6 : c6;
    r6 = rd ^ u6;
    a7 = kv || (!r6 && x inside {5'd17, 5'd18, 5'd20}) || (r6 && x inside {5'd11, 5'd13, 5'd14});
    c4 = y == 3'd7 ? (a7 ? 4'b0111 : 4'b1110) : k28 ? t4k[y] : t4d[y];
    u4 = $countones(c4) != 2;
    o4 = (r6 && (u4 || k28 || y == 3'd3)) ? ~c4 : c4;
    s6 = {<<{o6}};
    s4 = {<<{o4}};
    return {k & ~kv, r6 ^ u4, s4, s6};
  endfunction
  logic [3:0][9:0] do_nx;
  logic [3:0]      kerr_nx;
  logic            rd_t;
  always_comb begin
    rd_t = RD;
    for (int i = 0; i < 4; i++) {kerr_nx[i], rd_t, do_nx[i]} = enc(DI[i], KI[i], rd_t);
  end
  always_ff @(posedge CLK or negedge RST_n)
    if (!RST_n) begin
      DO <= '0;
      RD <= 1'b0;
      K_ERR <= '0;
    end else if (EN) begin
      DO <= do_nx;
      RD <= rd_t;
      K_ERR <= kerr_nx;
    end
endmodule

// File: tb/tb_tx_enc_8b10b.sv
// tb_tx_enc_8b10b: random and directed stimulus against a disparity-arithmetic 8b/10b model
module tb_tx_enc_8b10b;
  logic CLK = 1'b0, RST_n = 1'b0, EN = 1'b0;
  logic [3:0][7:0] DI = '0;
  logic [3:0] KI = '0;
  logic [3:0][9:0] DO;
  logic RD;
  logic [3:0] K_ERR;
  int checks = 0, errors = 0;
  logic [9:0] m_do [4] = '{default: '0};
  int m_rd = -1;
  logic [3:0] m_kerr = '0;
  logic [5:0] m6 [32] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
  logic [3:0] m4d [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
  logic [3:0] m4k [8] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};
  logic [7:0] vk [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE};

  tx_enc_8b10b dut (.CLK(CLK), .RST_n(RST_n), .EN(EN), .DI(DI), .KI(KI), .DO(DO), .RD(RD), .K_ERR(K_ERR));

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] rev10(input logic [9:0] s);
    logic [9:0] r;
    for (int b = 0; b < 10; b++) r[b] = s[9 - b];
    return r;
  endfunction

  function automatic int pick(input int p, input int n, input bit sp, input int rd);
    int alt = ~p & ((1 << n) - 1);
    int dp = 2 * $countones(p) - n;
    if (dp == 0) return (sp && rd > 0) ? alt : p;
    return ((dp > 0) == (rd < 0)) ? p : alt;
  endfunction

  task automatic enc(input logic [7:0] d, input logic k, inout int rd, output logic [9:0] cw, output logic err);
    int x = int'(d[4:0]);
    int y = int'(d[7:5]);
    bit valid = 0;
    int c6, c4, p4;
    foreach (vk[j]) if (k && d == vk[j]) valid = 1;
    c6 = pick(int'((valid && x == 28) ? 6'b001111 : m6[x]), 6, x == 7, rd);
    rd += 2 * $countones(c6) - 6;
    if (y == 7)
      p4 = (valid || (rd < 0 && x inside {17, 18, 20}) || (rd > 0 && x inside {11, 13, 14})) ? 4'b0111 : 4'b1110;
    else
      p4 = int'((valid && x == 28) ? m4k[y] : m4d[y]);
    c4 = pick(p4, 4, y == 3 || (valid && x == 28), rd);
    rd += 2 * $countones(c4) - 4;
    cw = rev10({c6[5:0], c4[3:0]});
    err = k && !valid;
  endtask

  task automatic step(input logic [3:0][7:0] d, input logic [3:0] k, input logic en);
    @(negedge CLK);
    DI = d;
    KI = k;
    EN = en;
    @(posedge CLK);
    #1;
    if (en) for (int i = 0; i < 4; i++) enc(d[i], k[i], m_rd, m_do[i], m_kerr[i]);
    for (int i = 0; i < 4; i++) chk($sformatf("do%0d", i), DO[i], m_do[i]);
    chk("rd", RD, m_rd > 0);
    chk("k_err", K_ERR, m_kerr);
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_do", DO, '0);
    chk("rst_rd", RD, 0);
    chk("rst_kerr", K_ERR, 0);
    @(negedge CLK);
    RST_n = 1'b1;
    step({4{8'hBC}}, 4'hF, 1'b1);
    chk("k285_s0", DO[0], rev10(10'b0011111010));
    chk("k285_s1", DO[1], rev10(10'b1100000101));
    chk("k285_s2", DO[2], rev10(10'b0011111010));
    chk("k285_s3", DO[3], rev10(10'b1100000101));
    chk("k285_rd", RD, 0);
    step({4{8'h00}}, 4'h0, 1'b1);
    for (int i = 0; i < 4; i++) chk($sformatf("d00_s%0d", i), DO[i], rev10(10'b1001110100));
    chk("d00_rd", RD, 0);
    step({8'h00, 8'h00, 8'h00, 8'hBC}, 4'h1, 1'b1);
    chk("k285_single", DO[0], rev10(10'b0011111010));
    chk("k285_single_rd", RD, 1);
    step({8'h00, 8'h00, 8'hF1, 8'hEB}, 4'h0, 1'b1);
    chk("d11_7_a7", DO[0], rev10(10'b1101001000));
    chk("d17_7_a7", DO[1], rev10(10'b1000110111));
    step({4{8'hB5}}, 4'h0, 1'b1);
    for (int i = 0; i < 4; i++) chk($sformatf("d21_5p_s%0d", i), DO[i], rev10(10'b1010101010));
    chk("d21_5p_rd", RD, 1);
    step({8'h00, 8'h00, 8'h00, 8'hBC}, 4'h1, 1'b1);
    step({4{8'hB5}}, 4'h0, 1'b1);
    for (int i = 0; i < 4; i++) chk($sformatf("d21_5m_s%0d", i), DO[i], rev10(10'b1010101010));
    chk("d21_5m_rd", RD, 0);
    step({8'h55, 8'hA3, 8'h00, 8'h1F}, 4'h2, 1'b1);
    chk("bad_k", K_ERR, 4'h2);
    step({8'h7C, 8'hFC, 8'hF7, 8'hFB}, 4'hF, 1'b1);
    chk("good_k_a", K_ERR, 4'h0);
    step({8'hFD, 8'hFE, 8'h1C, 8'hDC}, 4'hF, 1'b1);
    chk("good_k_b", K_ERR, 4'h0);
    for (int n = 0; n < 300; n++) begin
      logic [3:0][7:0] d;
      logic [3:0] k;
      for (int i = 0; i < 4; i++) begin
        k[i] = $urandom_range(0, 3) == 0;
        d[i] = (k[i] && $urandom_range(0, 3) != 0) ? vk[$urandom_range(0, 11)] : 8'($urandom);
      end
      step(d, k, $urandom_range(0, 4) != 0);
    end
    step({4{8'h0F}}, 4'h0, 1'b1);
    for (int n = 0; n < 3; n++) step({4{8'($urandom)}}, 4'($urandom), 1'b0);
    @(negedge CLK);
    DI = {4{8'h3C}};
    KI = 4'hF;
    EN = 1'b1;
    RST_n = 1'b0;
    #1;
    m_do = '{default: '0};
    m_rd = -1;
    m_kerr = '0;
    chk("async_rst_do", DO, '0);
    chk("async_rst_rd", RD, 0);
    chk("async_rst_kerr", K_ERR, 0);
    @(negedge CLK);
    RST_n = 1'b1;
    step({4{8'hBC}}, 4'hF, 1'b1);
    chk("post_rst_k285", DO[0], rev10(10'b0011111010));
    for (int n = 0; n < 100; n++) step({8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)}, 4'h0, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
